// File: rtl/logic_func_checker.sv
// ---------------------------------------------------------------------------
// logic_func_checker
//
// Exhaustive checker for an N_VARS-input boolean function. A minterm mask
// (bit i = f(i)) is loaded into the table register. A sweep then drives every
// input combination 0 .. 2^N_VARS-1 onto vars, one per clock. The response of
// the external implementation under test is compared against the canonical
// sum-of-products evaluation of the table. That evaluation is delayed by
// DUT_LAT cycles, so it lines up with the response of a pipelined DUT. A
// product-of-sums evaluation of the same table runs alongside as a
// self-consistency check.
//
// Parameters
//   N_VARS   number of function inputs (1..8)
//   DUT_LAT  response latency of the DUT in clocks (0..3, 0 = combinational)
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   tbl_wr        load tbl_din into the table (ignored while busy)
//   tbl_din       minterm mask, bit i = f(i)
//   start         begin a sweep (ignored while busy)
//   abort         stop the running sweep, no done pulse
//   vars          stimulus to the DUT, MSB = first variable
//   dut_s         DUT response
//   exp_s         expected response aligned with the dut_s sample
//   busy          high while sweeping or draining the latency pipeline
//   done          one-cycle pulse when a sweep completes
//   mismatch_cnt  failing combinations seen in the current/last sweep
//   fail_valid    at least one mismatch recorded
//   first_fail    vars value of the first mismatch
//   canon_err     sticky: SoP and PoS evaluations disagreed
// ---------------------------------------------------------------------------
module logic_func_checker #(
    parameter int N_VARS  = 4,
    parameter int DUT_LAT = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     tbl_wr,
    input  logic [(1<<N_VARS)-1:0]   tbl_din,
    input  logic                     start,
    input  logic                     abort,
    output logic [N_VARS-1:0]        vars,
    input  logic                     dut_s,
    output logic                     exp_s,
    output logic                     busy,
    output logic                     done,
    output logic [N_VARS:0]          mismatch_cnt,
    output logic                     fail_valid,
    output logic [N_VARS-1:0]        first_fail,
    output logic                     canon_err
);

    localparam int                TBL_W      = 1 << N_VARS;
    localparam logic [N_VARS-1:0] IDX_LAST   = '1;
    localparam logic [1:0]        DRAIN_LAST = 2'((DUT_LAT == 0) ? 0 : DUT_LAT - 1);

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

    state_t           state;
    logic [TBL_W-1:0] tbl;
    logic [1:0]       drain_cnt;

    // Canonical sum of products: OR of one AND term per set minterm.
    function automatic logic eval_sop(input logic [TBL_W-1:0] t,
                                      input logic [N_VARS-1:0] v);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < TBL_W; i++) begin
            if (t[i]) acc = acc | (&(~(v ^ N_VARS'(i))));
        end
        return acc;
    endfunction

    // Canonical product of sums: AND of one OR term per cleared minterm.
    function automatic logic eval_pos(input logic [TBL_W-1:0] t,
                                      input logic [N_VARS-1:0] v);
        logic acc;
        acc = 1'b1;
        for (int i = 0; i < TBL_W; i++) begin
            if (!t[i]) acc = acc & (|(v ^ N_VARS'(i)));
        end
        return acc;
    endfunction

    // The count tops out at 2^N_VARS, below all-ones, so saturation is only
    // a guard against wrap.
    function automatic logic [N_VARS:0] sat_inc(input logic [N_VARS:0] c);
        return (&c) ? c : c + (N_VARS+1)'(1);
    endfunction

    // ---- stage p0: evaluation on the registered stimulus ----
    logic sop_p0;
    logic pos_p0;
    logic vld_p0;
    logic in_sweep;
    logic flush;

    assign sop_p0   = eval_sop(tbl, vars);
    assign pos_p0   = eval_pos(tbl, vars);
    assign vld_p0   = (state == SWEEP);
    assign in_sweep = (state == SWEEP) || (state == DRAIN);
    assign flush    = abort && in_sweep;

    logic                exp_dly;
    logic                vld_dly;
    logic [N_VARS-1:0]   tag_dly;

    // ---- stages p1..pLAT: latency alignment with the DUT ----
    generate
        if (DUT_LAT > 0) begin : g_lat
            logic [DUT_LAT-1:0] vld_pn;
            logic [DUT_LAT-1:0] exp_pn;
            logic [N_VARS-1:0]  tag_pn [DUT_LAT];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_pn <= '0;
                    exp_pn <= '0;
                end else begin
                    vld_pn[0] <= vld_p0 && !flush;
                    exp_pn[0] <= sop_p0;
                    for (int k = 1; k < DUT_LAT; k++) begin
                        vld_pn[k] <= vld_pn[k-1] && !flush;
                        exp_pn[k] <= exp_pn[k-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                tag_pn[0] <= vars;
                for (int k = 1; k < DUT_LAT; k++) begin
                    tag_pn[k] <= tag_pn[k-1];
                end
            end

            assign vld_dly = vld_pn[DUT_LAT-1];
            assign exp_dly = exp_pn[DUT_LAT-1];
            assign tag_dly = tag_pn[DUT_LAT-1];
        end else begin : g_comb
            assign vld_dly = vld_p0;
            assign exp_dly = sop_p0;
            assign tag_dly = vars;
        end
    endgenerate

    assign exp_s = exp_dly;

    // ---- compare stage ----
    logic cmp_en;
    logic miss;

    assign cmp_en = vld_dly && !flush;
    assign miss   = cmp_en && (dut_s != exp_dly);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            tbl          <= '0;
            vars         <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            mismatch_cnt <= '0;
            fail_valid   <= 1'b0;
            first_fail   <= '0;
            canon_err    <= 1'b0;
            drain_cnt    <= '0;
        end else begin
            done <= 1'b0;

            if (sop_p0 != pos_p0) canon_err <= 1'b1;

            // The write lands at this edge, so a start in the same cycle
            // sweeps against the new table.
            if (tbl_wr && !in_sweep) tbl <= tbl_din;

            if (miss) begin
                mismatch_cnt <= sat_inc(mismatch_cnt);
                if (!fail_valid) begin
                    fail_valid <= 1'b1;
                    first_fail <= tag_dly;
                end
            end

            case (state)
                IDLE, DONE: begin
                    if (start && !abort) begin
                        state        <= SWEEP;
                        busy         <= 1'b1;
                        vars         <= '0;
                        mismatch_cnt <= '0;
                        fail_valid   <= 1'b0;
                        first_fail   <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                SWEEP: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (vars == IDX_LAST) begin
                        if (DUT_LAT == 0) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state     <= DRAIN;
                            drain_cnt <= '0;
                        end
                    end else begin
                        vars <= vars + N_VARS'(1);
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (drain_cnt == DRAIN_LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_logic_func_checker.sv
// ---------------------------------------------------------------------------
// tb_logic_func_checker
//
// Drives two checker instances from shared controls: u_chk0 (DUT_LAT=0) and
// u_chk2 (DUT_LAT=2). The DUT seen by u_chk2 is a two-register delay of the
// reference function. The DUT seen by u_chk0 is selected by mode0:
//   0 correct, 1 wrong only at vars=13, 2 constant 1, 3 two-cycle delayed.
// Expected stimulus/response pairs are queued at launch and popped while the
// checkers are busy.
// ---------------------------------------------------------------------------
module tb_logic_func_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        tbl_wr;
    logic [15:0] tbl_din;
    logic        start;
    logic        abort;

    logic [3:0]  vars0, vars2;
    logic        dut0_s, dut2_s;
    logic        exp_s0, exp_s2;
    logic        busy0, busy2;
    logic        done0, done2;
    logic [4:0]  mm0, mm2;
    logic        fv0, fv2;
    logic [3:0]  ff0, ff2;
    logic        ce0, ce2;

    logic_func_checker #(.N_VARS(4), .DUT_LAT(0)) u_chk0 (
        .clk(clk), .rst_n(rst_n), .tbl_wr(tbl_wr), .tbl_din(tbl_din),
        .start(start), .abort(abort), .vars(vars0), .dut_s(dut0_s),
        .exp_s(exp_s0), .busy(busy0), .done(done0), .mismatch_cnt(mm0),
        .fail_valid(fv0), .first_fail(ff0), .canon_err(ce0)
    );

    logic_func_checker #(.N_VARS(4), .DUT_LAT(2)) u_chk2 (
        .clk(clk), .rst_n(rst_n), .tbl_wr(tbl_wr), .tbl_din(tbl_din),
        .start(start), .abort(abort), .vars(vars2), .dut_s(dut2_s),
        .exp_s(exp_s2), .busy(busy2), .done(done2), .mismatch_cnt(mm2),
        .fail_valid(fv2), .first_fail(ff2), .canon_err(ce2)
    );

    // Reference function and DUT models
    logic [15:0] ref_tbl;
    logic [1:0]  mode0;
    logic        e1 = 1'b0, e2 = 1'b0, d1 = 1'b0, d2 = 1'b0;

    always @(posedge clk) begin
        e1 <= ref_tbl[vars0];
        e2 <= e1;
        d1 <= ref_tbl[vars2];
        d2 <= d1;
    end

    always_comb begin
        dut0_s = ref_tbl[vars0];
        case (mode0)
            2'd1:    dut0_s = (vars0 == 4'd13) ? 1'b1 : ref_tbl[vars0];
            2'd2:    dut0_s = 1'b1;
            2'd3:    dut0_s = e2;
            default: dut0_s = ref_tbl[vars0];
        endcase
    end

    assign dut2_s = d2;

    // Scoreboard
    typedef struct packed {
        logic [3:0] v;
        logic       e;
    } exp_t;

    exp_t q0[$];
    logic q2[$];

    int checks = 0;
    int errors = 0;
    int b0, b2, dn0, dn2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic fail_now(input string tag);
        checks++;
        errors++;
        $error("FAIL %s observed=expired expected=event", tag);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_vars0"}, 32'(vars0), 0);
        check({tag, "_exp0"},  32'(exp_s0), 0);
        check({tag, "_busy0"}, 32'(busy0), 0);
        check({tag, "_done0"}, 32'(done0), 0);
        check({tag, "_mm0"},   32'(mm0), 0);
        check({tag, "_fv0"},   32'(fv0), 0);
        check({tag, "_ff0"},   32'(ff0), 0);
        check({tag, "_ce0"},   32'(ce0), 0);
        check({tag, "_vars2"}, 32'(vars2), 0);
        check({tag, "_exp2"},  32'(exp_s2), 0);
        check({tag, "_busy2"}, 32'(busy2), 0);
        check({tag, "_done2"}, 32'(done2), 0);
        check({tag, "_mm2"},   32'(mm2), 0);
        check({tag, "_fv2"},   32'(fv2), 0);
        check({tag, "_ff2"},   32'(ff2), 0);
        check({tag, "_ce2"},   32'(ce2), 0);
    endtask

    task automatic load_table(input logic [15:0] t);
        tbl_din = t;
        tbl_wr  = 1'b1;
        step();
        tbl_wr  = 1'b0;
        ref_tbl = t;
    endtask

    task automatic launch(input logic wr, input logic [15:0] t);
        exp_t ent;
        tbl_wr  = wr;
        tbl_din = t;
        start   = 1'b1;
        step();
        tbl_wr  = 1'b0;
        start   = 1'b0;
        if (wr) ref_tbl = t;
        for (int i = 0; i < 16; i++) begin
            ent.v = 4'(i);
            ent.e = ref_tbl[i];
            q0.push_back(ent);
            q2.push_back(ref_tbl[i]);
        end
    endtask

    // Follows both checkers until neither is busy. With disturb set, a junk
    // table write and a start are pulsed mid-sweep; both must be ignored.
    task automatic monitor(input logic disturb);
        exp_t ent;
        logic ev;
        int   guard;
        b0 = 0; b2 = 0; dn0 = 0; dn2 = 0; guard = 0;
        forever begin
            if (done0) dn0++;
            if (done2) dn2++;
            tbl_wr = 1'b0;
            start  = 1'b0;
            if (!busy0 && !busy2) break;
            if (guard > 60) begin
                fail_now("monitor_bound");
                break;
            end
            if (busy0) begin
                if (q0.size() != 0) begin
                    ent = q0.pop_front();
                    check("sweep_vars0", 32'(vars0), 32'(ent.v));
                    check("sweep_exp0", 32'(exp_s0), 32'(ent.e));
                end else begin
                    fail_now("q0_underflow");
                end
                b0++;
            end
            if (busy2) begin
                if (b2 >= 2) begin
                    if (q2.size() != 0) begin
                        ev = q2.pop_front();
                        check("sweep_exp2", 32'(exp_s2), 32'(ev));
                    end else begin
                        fail_now("q2_underflow");
                    end
                end
                b2++;
            end
            if (disturb && b0 == 5) begin
                tbl_wr  = 1'b1;
                tbl_din = ~ref_tbl;
                start   = 1'b1;
            end
            step();
            guard++;
        end
        check("q0_drained", 32'(q0.size()), 0);
        check("q2_drained", 32'(q2.size()), 0);
    endtask

    task automatic wait_vars(input logic [3:0] v);
        for (int k = 0; k < 40; k++) begin
            if (busy0 && vars0 == v) break;
            step();
        end
        check("wait_vars", 32'(vars0), 32'(v));
    endtask

    initial begin
        rst_n = 1'b1; tbl_wr = 1'b0; tbl_din = '0; start = 1'b0; abort = 1'b0;
        mode0 = 2'd0; ref_tbl = '0;
        #2 rst_n = 1'b0;
        #2 check_zero("reset");
        #20 rst_n = 1'b1;
        step();

        // Correct DUT, with ignored write/start mid-sweep
        load_table(16'h5363);
        launch(1'b0, 16'h0);
        monitor(1'b1);
        check("t1_busy0", 32'(b0), 16);
        check("t1_busy2", 32'(b2), 18);
        check("t1_done0", 32'(dn0), 1);
        check("t1_done2", 32'(dn2), 1);
        check("t1_mm0", 32'(mm0), 0);
        check("t1_fv0", 32'(fv0), 0);
        check("t1_ce0", 32'(ce0), 0);
        check("t1_mm2", 32'(mm2), 0);
        check("t1_fv2", 32'(fv2), 0);

        // Back-to-back: u_chk2 is in its DONE cycle here
        launch(1'b0, 16'h0);
        monitor(1'b0);
        check("b2b_busy0", 32'(b0), 16);
        check("b2b_busy2", 32'(b2), 18);
        check("b2b_done2", 32'(dn2), 1);
        check("b2b_mm2", 32'(mm2), 0);

        // Wrong only at vars=13
        mode0 = 2'd1;
        launch(1'b0, 16'h0);
        monitor(1'b0);
        check("t2_mm0", 32'(mm0), 1);
        check("t2_ff0", 32'(ff0), 13);
        check("t2_fv0", 32'(fv0), 1);
        check("t2_mm2", 32'(mm2), 0);

        // Two-cycle DUT against both latency settings
        mode0 = 2'd3;
        launch(1'b0, 16'h0);
        monitor(1'b0);
        check("t3_mm0_nonzero", 32'(mm0 != 0), 1);
        check("t3_mm2", 32'(mm2), 0);
        check("t3_busy2", 32'(b2), 18);
        check("t3_ce2", 32'(ce2), 0);

        // Empty table, DUT stuck at 1: every combination fails
        mode0 = 2'd2;
        load_table(16'h0000);
        launch(1'b0, 16'h0);
        monitor(1'b0);
        check("t4_mm0", 32'(mm0), 16);
        check("t4_ff0", 32'(ff0), 0);
        check("t4_fv0", 32'(fv0), 1);
        check("t4_mm2", 32'(mm2), 0);

        // Abort at idx 7
        mode0 = 2'd0;
        load_table(16'h5363);
        launch(1'b0, 16'h0);
        wait_vars(4'd7);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t5_busy0", 32'(busy0), 0);
        check("t5_busy2", 32'(busy2), 0);
        check("t5_done0", 32'(done0), 0);
        check("t5_done2", 32'(done2), 0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("t5_nodone0", 32'(done0), 0);
            check("t5_nodone2", 32'(done2), 0);
        end
        q0.delete();
        q2.delete();

        // abort and start together in IDLE: abort wins
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        check("t5_abort_wins0", 32'(busy0), 0);
        check("t5_abort_wins2", 32'(busy2), 0);

        // Write and start together: sweep uses the new table
        launch(1'b1, 16'hA5C3);
        monitor(1'b0);
        check("t5_busy0", 32'(b0), 16);
        check("t5_done0", 32'(dn0), 1);
        check("t5_mm0", 32'(mm0), 0);
        check("t5_mm2", 32'(mm2), 0);

        // Asynchronous reset at idx 9
        launch(1'b0, 16'h0);
        wait_vars(4'd9);
        check("t6_busy_pre", 32'(busy0), 1);
        rst_n = 1'b0;
        #2 check_zero("async_reset");
        #2 rst_n = 1'b1;
        ref_tbl = '0;
        q0.delete();
        q2.delete();
        step();
        launch(1'b0, 16'h0);
        monitor(1'b0);
        check("t6_busy0", 32'(b0), 16);
        check("t6_busy2", 32'(b2), 18);
        check("t6_done0", 32'(dn0), 1);
        check("t6_mm0", 32'(mm0), 0);
        check("t6_ce0", 32'(ce0), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
